// File: rtl/isa_pkg.sv
// Shared ISA definitions for the issue stage: field positions, ALU op codes,
// architectural sizes and the immediate sign-extension helper.
package isa_pkg;

  localparam int unsigned NREGS = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned RD_MSB  = 27;
  localparam int unsigned RD_LSB  = 24;
  localparam int unsigned RS1_MSB = 23;
  localparam int unsigned RS1_LSB = 20;
  localparam int unsigned RS2_MSB = 19;
  localparam int unsigned RS2_LSB = 16;
  localparam int unsigned IMMSEL_BIT = 15;
  localparam int unsigned IMM_MSB = 14;
  localparam int unsigned IMM_W   = 15;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0101
  } alu_op_e;

  function automatic logic [DW-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DW-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/regfile_16x32.sv
// 16x32 register file: two asynchronous read ports, one synchronous write
// port, r0 hardwired to zero.
module regfile_16x32
  import isa_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr1_i,
  input  logic [AW-1:0] raddr2_i,
  output logic [DW-1:0] rdata1_o,
  output logic [DW-1:0] rdata2_o
);

  logic [DW-1:0] mem_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/operand_issue_stage.sv
// Decode/issue stage ahead of the ALU: register read with writeback bypass,
// scoreboard-based RAW/WAW stalling and a valid/ready output register.
module operand_issue_stage
  import isa_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] operand1,
  output logic [DW-1:0] operand2,
  output logic [3:0]    op,
  output logic [AW-1:0] rd
);

  logic [3:0]       f_op;
  logic [AW-1:0]    f_rd, f_rs1, f_rs2;
  logic             f_imm_sel;
  logic [IMM_W-1:0] f_imm;

  assign f_op      = instr[OP_MSB:OP_LSB];
  assign f_rd      = instr[RD_MSB:RD_LSB];
  assign f_rs1     = instr[RS1_MSB:RS1_LSB];
  assign f_rs2     = instr[RS2_MSB:RS2_LSB];
  assign f_imm_sel = instr[IMMSEL_BIT];
  assign f_imm     = instr[IMM_MSB:0];

  logic [DW-1:0] rf_rd1, rf_rd2, src1, src2;

  regfile_16x32 u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_en),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr1_i (f_rs1),
    .raddr2_i (f_rs2),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2)
  );

  assign src1 = (wb_en && wb_addr == f_rs1 && f_rs1 != '0) ? wb_data : rf_rd1;
  assign src2 = (wb_en && wb_addr == f_rs2 && f_rs2 != '0) ? wb_data : rf_rd2;

  logic [NREGS-1:0] pend_q, pend_d, wb_clr, pend_eff;
  logic             hazard, fire;

  // A writeback landing this cycle already resolves its pending bit.
  assign wb_clr   = wb_en ? (NREGS'(1) << wb_addr) : '0;
  assign pend_eff = pend_q & ~wb_clr;

  assign hazard   = pend_eff[f_rs1]
                  | (!f_imm_sel && pend_eff[f_rs2])
                  | ((f_rd != '0) && pend_eff[f_rd]);
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;

  logic          valid_q, valid_d;
  logic [DW-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;

  always_comb begin
    pend_d  = pend_eff;
    valid_d = valid_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    op_d    = op_q;
    rd_d    = rd_q;
    if (fire) begin
      if (f_rd != '0) pend_d[f_rd] = 1'b1;
      valid_d = 1'b1;
      op1_d   = src1;
      op2_d   = f_imm_sel ? sext_imm(f_imm) : src2;
      op_d    = f_op;
      rd_d    = f_rd;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
    end
  end

  assign out_valid = valid_q;
  assign operand1  = op1_q;
  assign operand2  = op2_q;
  assign op        = op_q;
  assign rd        = rd_q;

endmodule
